nibble_add_seq: RTL and testbench
=================================

# nibble_add_seq

Multi-cycle WIDTH-bit add/subtract sequencer that time-shares one `adder4` 4-bit carry-lookahead slice across WIDTH/4 nibbles, least-significant nibble first. A registered carry connects one nibble to the next. The block sits beside the ALU for area-constrained builds: it accepts operands with a start/busy/done handshake and publishes registered sum and flags when the operation completes.

## Interface
**Parameters**
- `WIDTH`, default 32: operand width. Must be a multiple of 4 and at least 8. N = WIDTH/4 nibble steps.

**Ports**
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: request. Sampled only when the FSM is in IDLE or DONE.
- `mode`  in  1: 0 = add, 1 = subtract (A − B). Latched with `start`.
- `a`  in  WIDTH: operand A. Latched with `start`.
- `b`  in  WIDTH: operand B. Latched with `start`.
- `busy`  out  1: high while nibbles are being processed.
- `done`  out  1: one-cycle pulse when results become valid.
- `sum`  out  WIDTH: result, held until the next completion.
- `cf`  out  1: carry out of the MSB nibble (raw; for subtract, 1 = no borrow).
- `of`  out  1: signed overflow.
- `zf`  out  1: present only with `NIBBLE_SEQ_ZF_EN` (see Configuration).

## Operation
**FSM states:** IDLE, RUN, DONE.
- IDLE → RUN: on `start`=1. Latch `a`, `b`, `mode`; clear nibble index `k`; load the carry register with `mode`.
- RUN: each cycle, drive the slice as follows.
  - A = a_q[4k+3:4k], B = b_q[4k+3:4k], Cin = carry_q, mode = mode_q.
  - Write the slice S into partial-sum bits [4k+3:4k].
  - Load carry_q with the slice CF.
  - Increment k.
- RUN → DONE: when k = N−1 is processed. On that edge:
  - Copy the partial sum to `sum`.
  - Load `cf` with the final slice CF.
  - Compute `of` = (a_q[W−1] == (b_q[W−1]^mode_q)) && (S_final[W−1] != a_q[W−1]).
  - The slice OF output is not used.
- DONE → RUN: if `start`=1 (back-to-back); operands are latched exactly as from IDLE.
- DONE → IDLE: otherwise.
- `start` while in RUN is ignored; no queuing.
- `sum`, `cf`, `of` (and `zf`) change only on the completion edge or on reset. Intermediate nibbles are never visible.
- Arithmetic is modulo 2^WIDTH. Operand bits are not interpreted beyond the add/sub in the slice.

## Timing
- Reset (`rst_n`=0 at an edge): state = IDLE, k = 0, carry_q = 0, `busy` = 0, `done` = 0, `sum` = 0, `cf` = 0, `of` = 0, `zf` = 0.
  - Reset takes priority over `start`.
  - Reset mid-RUN aborts the operation: no `done`, and outputs are zeroed.
- Latency:
  - `start` accepted at edge E.
  - `busy` = 1 from after E through edge E+N−1 (N cycles).
  - Results are registered at edge E+N; `done` = 1 and `busy` = 0 for the cycle after E+N.
- `done` is high exactly while the state is DONE, so it is never longer than one cycle.
  - Back-to-back: a `start` in the DONE cycle gives `busy` = 1 in the next cycle.
  - Throughput is therefore one operation per N+1 cycles.
- `busy` and `done` are never high simultaneously.

## Configuration
- `NIBBLE_SEQ_ZF_EN` defined:
  - Adds the output `zf`, registered on the completion edge as (final sum == 0). Reset value is 0.
  - The per-nibble zero accumulator is computed in RUN alongside the sum.
- Undefined: the `zf` port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=32, N=8.
- **Carry wrap:** add 0x00000001 + 0xFFFFFFFF → `done` 8 cycles after accept; `sum`=0x00000000, `cf`=1, `of`=0, `zf`=1 (with macro).
- **Signed add overflow:** add 0x7FFFFFFF + 0x00000001 → `sum`=0x80000000, `cf`=0, `of`=1. Then add 0x80000000 + 0x80000000 → `sum`=0, `cf`=1, `of`=1.
- **Subtract:** 0x00000005 − 0x00000007 → `sum`=0xFFFFFFFE, `cf`=0, `of`=0. Then 0x80000000 − 0x00000001 → `sum`=0x7FFFFFFF, `cf`=1, `of`=1.
- **Handshake:**
  - Pulse `start` with new operands during RUN cycle 3 → ignored; the original result is delivered.
  - Assert `start` in the DONE cycle → `busy`=1 on the next cycle, second result after 8 more cycles.
  - Prior `sum` holds until the second result's completion edge.
- **Reset mid-operation:** `rst_n`=0 for one edge at RUN cycle 4 → `busy`=0, `done` never pulses, `sum`/`cf`/`of`=0. A following add 0x12345678 + 0x11111111 → 0x23456789.
- **Random regression:** 1000 random (a, b, mode) triples checked against a behavioural a±b model for `sum`, `cf`, `of` (and `zf`), with exact cycle count N per operation.

Source files
------------

// File: rtl/nibble_add_seq_if.sv
// nibble_add_seq_if: start/busy/done bundle for the nibble add/sub sequencer.
// master: requester (start, mode, a, b); slave: sequencer (busy, done, sum, cf, of, zf).
interface nibble_add_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cf;
  logic             of;
`ifdef NIBBLE_SEQ_ZF_EN
  logic             zf;
`endif

  modport master (
    output start, mode, a, b,
`ifdef NIBBLE_SEQ_ZF_EN
    input  zf,
`endif
    input  busy, done, sum, cf, of
  );

  modport slave (
    input  start, mode, a, b,
`ifdef NIBBLE_SEQ_ZF_EN
    output zf,
`endif
    output busy, done, sum, cf, of
  );
endinterface

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: WIDTH-bit add/sub run through one 4-bit CLA slice, LSB nibble first.
// Ports: clk, rst_n (sync, active-low), bus (slave). Option macro: NIBBLE_SEQ_ZF_EN adds zf.
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       mode,
  output logic [3:0] s,
  output logic       cf,
  output logic       of
);
  logic [3:0] bx;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Subtract is A + ~B + 1; the +1 arrives through cin.
  assign bx = b ^ {4{mode}};
  assign g  = a & bx;
  assign p  = a ^ bx;

  assign c[0] = cin;
  assign c[1] = g[0]
              | (p[0] & c[0]);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s  = p ^ c[3:0];
  assign cf = c[4];
  assign of = c[4] ^ c[3];
endmodule

module nibble_add_seq #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  nibble_add_seq_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic             carry_q;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] sum_q;
  logic             cf_q;
  logic             of_q;
`ifdef NIBBLE_SEQ_ZF_EN
  logic             nz_q;
  logic             zf_q;
`endif

  logic [3:0] na;
  logic [3:0] nb;
  logic [3:0] ns;
  logic       ncf;
  logic       nof;
  logic       last;
  logic       of_next;

  assign na   = a_q[4*k +: 4];
  assign nb   = b_q[4*k +: 4];
  assign last = (k == KW'(N - 1));

  adder4 u_slice (
    .a    (na),
    .b    (nb),
    .cin  (carry_q),
    .mode (mode_q),
    .s    (ns),
    .cf   (ncf),
    .of   (nof)
  );

  // Overflow from operand/result signs; only meaningful on the last nibble.
  assign of_next = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ mode_q))
                && (ns[3] != a_q[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      psum    <= '0;
      sum_q   <= '0;
      cf_q    <= 1'b0;
      of_q    <= 1'b0;
`ifdef NIBBLE_SEQ_ZF_EN
      nz_q    <= 1'b0;
      zf_q    <= 1'b0;
`endif
    end else begin
      unique case (1'b1)
        state == RUN: begin
          psum[4*k +: 4] <= ns;
          carry_q        <= ncf;
          k              <= k + 1'b1;
`ifdef NIBBLE_SEQ_ZF_EN
          nz_q           <= nz_q | (|ns);
`endif
          if (last) begin
            state <= DONE;
            sum_q <= {ns, psum[WIDTH-5:0]};
            cf_q  <= ncf;
            of_q  <= of_next;
`ifdef NIBBLE_SEQ_ZF_EN
            zf_q  <= ~(nz_q | (|ns));
`endif
            // Slice overflow must agree with the sign-based form.
            assert (nof == of_next);
          end
        end
        default: begin
          if (bus.start) begin
            state   <= RUN;
            a_q     <= bus.a;
            b_q     <= bus.b;
            mode_q  <= bus.mode;
            carry_q <= bus.mode;
            k       <= '0;
`ifdef NIBBLE_SEQ_ZF_EN
            nz_q    <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cf   = cf_q;
  assign bus.of   = of_q;
`ifdef NIBBLE_SEQ_ZF_EN
  assign bus.zf   = zf_q;
`endif
endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: scoreboard bench for nibble_add_seq (WIDTH=32).
// Driver pushes expected results; negedge monitor pops and compares on done.
module tb_nibble_add_seq;
  localparam int W = 32;
  localparam int N = W / 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cf;
    logic         of;
    logic         zf;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;
  exp_t drop_e;

  nibble_add_seq_if #(.WIDTH(W)) bus ();

  nibble_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 want no pending op");
      end else begin
        mon_e = sb.pop_front();
        chk("sum", bus.sum, mon_e.sum);
        chk("cf", W'(bus.cf), W'(mon_e.cf));
        chk("of", W'(bus.of), W'(mon_e.of));
`ifdef NIBBLE_SEQ_ZF_EN
        chk("zf", W'(bus.zf), W'(mon_e.zf));
`endif
        chk("latency", W'(cyc - mon_e.acc), W'(N));
        chk("busy_with_done", W'(bus.busy), '0);
      end
    end
  end

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic m,
                       logic [W-1:0] es, logic ec, logic eo);
    int   t;
    exp_t e;
    t = 0;
    while (bus.busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got busy=1 want idle");
    end
    bus.a     = a;
    bus.b     = b;
    bus.mode  = m;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e.sum = es;
    e.cf  = ec;
    e.of  = eo;
    e.zf  = (es == '0);
    e.acc = cyc;
    sb.push_back(e);
    chk("busy_after_accept", W'(bus.busy), W'(1));
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!bus.done && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus.done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got done=0 want done pulse");
    end
  endtask

  task automatic run_model(logic [W-1:0] a, logic [W-1:0] b, logic m);
    longint sa;
    longint sbv;
    longint r;
    logic [W-1:0] s;
    logic c;
    logic o;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    r   = m ? (sa - sbv) : (sa + sbv);
    o   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    s   = m ? (a - b) : (a + b);
    c   = m ? (a >= b) : ((33'(a) + 33'(b)) >= 33'h1_0000_0000);
    issue(a, b, m, s, c, o);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_sum", bus.sum, '0);
    chk("rst_cf", W'(bus.cf), '0);
    chk("rst_of", W'(bus.of), '0);
`ifdef NIBBLE_SEQ_ZF_EN
    chk("rst_zf", W'(bus.zf), '0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    wait_done();
    @(negedge clk);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    wait_done();
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    wait_done();
    issue(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    wait_done();
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    wait_done();
    @(negedge clk);

    issue(32'h0000_1000, 32'h0000_0234, 1'b0, 32'h0000_1234, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'hFFFF_FFFF;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_ignores_start", W'(bus.busy), W'(1));
    wait_done();
    @(negedge clk);
    chk("idle_after_done", W'({bus.busy, bus.done}), '0);

    issue(32'h1111_1111, 32'h2222_2222, 1'b0, 32'h3333_3333, 1'b0, 1'b0);
    wait_done();
    issue(32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("sum_hold", bus.sum, 32'h3333_3333);
    wait_done();
    @(negedge clk);

    issue(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drop_e = sb.pop_back();
    @(negedge clk);
    chk("abort_busy", W'(bus.busy), '0);
    chk("abort_done", W'(bus.done), '0);
    chk("abort_sum", bus.sum, '0);
    chk("abort_cf", W'(bus.cf), '0);
    chk("abort_of", W'(bus.of), '0);
    repeat (12) @(negedge clk);
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
    wait_done();

    for (int i = 0; i < 1000; i++) begin
      run_model($urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_done();
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", W'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
